enemy_wave_scheduler: RTL
=========================

Name: enemy_wave_scheduler

Overview:
- Game-level sequencer for the three enemy_control slots.
- Turns the slow spawn-timer pulses into per-slot spawn requests, using round-robin arbitration over free slots.
- Picks a target base for each spawn, counts enemies per wave and advances waves.
- Tracks remaining bases and signals game over or win.
- Sits between timer_cluster and the enemy_control instances, all in the clk100MHz domain.

Parameters:
- ENEMIES_BASE, 4, enemies spawned in wave 1.
- ENEMIES_STEP, 2, extra enemies per subsequent wave. Quota saturates at 15.
- MAX_WAVE, 8, last wave. Clearing it means a win.
- BASES, 3, bases at game start (1..3).
- LFSR_SEED, 8'hA5, target LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from menu/button logic; starts or restarts a game.
- spawn_tick  in  1  one-cycle pulse from the timer_cluster slow output.
- slot_active  in  3  bit i high while enemy i is on screen (enemy_control spawn output).
- base_hit  in  1  one-cycle pulse: an enemy reached a base.
- spawn_req  out  3  one-hot, one-cycle pulse to the enemy_control spawn_pulse of slot i.
- target_sel  out  2  target base (1..3). Valid only while spawn_req != 0.
- wave  out  4  current wave number. 0 when idle.
- bases_left  out  2  remaining bases.
- playing  out  1  high in states WSTART, SPAWN and CLEAR.
- game_over  out  1  high in OVER.
- game_won  out  1  high in WIN.

Behaviour:
- Reset values:
  - state IDLE.
  - spawn_req 0, target_sel 0, wave 0.
  - bases_left BASES.
  - playing, game_over, game_won all 0.
  - quota 0, reserved mask 0, rr_ptr 2 (so slot 0 is tried first).
  - lfsr LFSR_SEED.
- Reset mid-game: takes effect on the next edge and overrides all other inputs.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Shifts every cycle regardless of state.
  - target_sel mapping from lfsr[1:0]: 0→1, 1→2, 2→3, 3→2.
- State IDLE:
  - On start: wave←1, bases_left←BASES, go to WSTART.
  - spawn_tick and base_hit are ignored.
- State WSTART (one cycle):
  - quota ← min(15, ENEMIES_BASE + (wave−1)·ENEMIES_STEP), computed at 5-bit width then clamped.
  - Go to SPAWN.
- State SPAWN:
  - Slot i is free when slot_active[i]=0 and reserved[i]=0.
  - On spawn_tick with at least one free slot and quota>0:
    - Grant the first free slot searching rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
    - Next cycle, spawn_req[g]=1 for exactly one cycle and target_sel is driven from the LFSR mapping. Latency is 1 cycle.
    - reserved[g]←1, rr_ptr←g, quota←quota−1.
  - A spawn_tick with no free slot is dropped, not queued. quota is unchanged.
  - When quota reaches 0 (after the grant is issued), go to CLEAR.
- reserved[i] clears on the first cycle slot_active[i] is sampled high.
- State CLEAR:
  - Waits for slot_active==0 and reserved==0.
  - Then: if wave==MAX_WAVE go to WIN; otherwise wave←wave+1 and go to WSTART.
- base_hit (in WSTART, SPAWN or CLEAR):
  - bases_left←bases_left−1.
  - On reaching 0, go to OVER the same edge. Any grant decided in that cycle is suppressed (no spawn_req).
  - bases_left never wraps below 0.
- States OVER and WIN:
  - Outputs hold; inputs other than start are ignored.
  - On start: reinit exactly as from IDLE (wave←1, bases_left←BASES, reserved←0, rr_ptr←2) and go to WSTART.
- Simultaneous start while playing: ignored.
- Simultaneous spawn_tick and base_hit in SPAWN without game over: both take effect.
- Assertions:
  - spawn_req is one-hot or zero.
  - spawn_req never targets a slot with slot_active=1.

Test Plan:
- Reset then start, all slots idle, three spawn_ticks 10 cycles apart → spawn_req 001, 010, 100, each 1 cycle long and 1 cycle after its tick; wave=1.
- Wave 1 with slot_active driven high 2 cycles after each request and cleared later; 4 ticks → 4 requests (quota 4), then CLEAR. After slot_active==0, wave=2 and the next quota is 6.
- Slots 0 and 2 active, slot 1 free, spawn_tick → spawn_req 010. With all three active, spawn_tick → no request and quota unchanged.
- base_hit ×3 during wave 1 → bases_left 3,2,1,0; game_over=1 on the third. A spawn_tick coincident with the third hit gives no spawn_req.
- MAX_WAVE=2 build: clear waves 1 and 2 → game_won=1, wave=2. Then start → wave=1, bases_left=3, playing=1.
- rst asserted mid-SPAWN with a request pending → next cycle state IDLE, spawn_req=0, wave=0, lfsr=8'hA5.

Source files
------------

// File: rtl/enemy_wave_scheduler.sv
// Wave sequencer for the three enemy slots: round-robin spawn grants,
// LFSR base targeting, per-wave quota, base tracking and win/lose states.
module enemy_wave_scheduler #(
    parameter int         ENEMIES_BASE = 4,
    parameter int         ENEMIES_STEP = 2,
    parameter int         MAX_WAVE     = 8,
    parameter int         BASES        = 3,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       spawn_tick,
    input  logic [2:0] slot_active,
    input  logic       base_hit,
    output logic [2:0] spawn_req,
    output logic [1:0] target_sel,
    output logic [3:0] wave,
    output logic [1:0] bases_left,
    output logic       playing,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {IDLE, WSTART, SPAWN, CLEAR, OVER, WIN} state_t;

    state_t     state_q, state_d;
    logic [3:0] wave_q, wave_d;
    logic [1:0] bases_q, bases_d;
    logic [3:0] quota_q, quota_d;
    logic [2:0] res_q, res_d;
    logic [1:0] rr_q, rr_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] spawn_req_q, spawn_req_d;
    logic [1:0] target_q, target_d;
    logic       playing_q, playing_d;
    logic       over_q, over_d;
    logic       won_q, won_d;

    logic [2:0] free;
    logic [1:0] c1, c2, g;
    logic [1:0] tsel;
    logic [4:0] quota_raw;
    logic       playing_st, hit_over, grant;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    always_comb begin
        free = ~slot_active & ~res_q;
        c1   = inc3(rr_q);
        c2   = inc3(c1);
        if (free[c1])      g = c1;
        else if (free[c2]) g = c2;
        else               g = rr_q;

        unique case (lfsr_q[1:0])
            2'd0:    tsel = 2'd1;
            2'd1:    tsel = 2'd2;
            2'd2:    tsel = 2'd3;
            default: tsel = 2'd2;
        endcase

        quota_raw = 5'(ENEMIES_BASE)
                  + 5'(({1'b0, wave_q} - 5'd1) * 5'(ENEMIES_STEP));

        playing_st = (state_q == WSTART) || (state_q == SPAWN)
                  || (state_q == CLEAR);
        hit_over   = base_hit && playing_st && (bases_q <= 2'd1);
        // A game-ending hit cancels any grant decided in the same cycle
        grant      = (state_q == SPAWN) && spawn_tick && (|free)
                  && (quota_q != 4'd0) && !hit_over;

        state_d     = state_q;
        wave_d      = wave_q;
        bases_d     = bases_q;
        quota_d     = quota_q;
        res_d       = res_q & ~slot_active;
        rr_d        = rr_q;
        lfsr_d      = {lfsr_q[6:0],
                       lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        spawn_req_d = 3'b000;
        target_d    = target_q;

        unique case (state_q)
            IDLE, OVER, WIN: begin
                if (start) begin
                    wave_d  = 4'd1;
                    bases_d = 2'(BASES);
                    res_d   = 3'b000;
                    rr_d    = 2'd2;
                    state_d = WSTART;
                end
            end
            WSTART: begin
                quota_d = (quota_raw > 5'd15) ? 4'd15 : quota_raw[3:0];
                state_d = SPAWN;
            end
            SPAWN: begin
                if (grant) begin
                    spawn_req_d = 3'b001 << g;
                    target_d    = tsel;
                    res_d       = res_d | (3'b001 << g);
                    rr_d        = g;
                    quota_d     = quota_q - 4'd1;
                    if (quota_q == 4'd1) state_d = CLEAR;
                end else if (quota_q == 4'd0) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (slot_active == 3'b000 && res_q == 3'b000) begin
                    if (wave_q == 4'(MAX_WAVE)) begin
                        state_d = WIN;
                    end else begin
                        wave_d  = wave_q + 4'd1;
                        state_d = WSTART;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (base_hit && playing_st) begin
            if (bases_q != 2'd0) bases_d = bases_q - 2'd1;
            if (hit_over) state_d = OVER;
        end

        playing_d = (state_d == WSTART) || (state_d == SPAWN)
                 || (state_d == CLEAR);
        over_d    = (state_d == OVER);
        won_d     = (state_d == WIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wave_q      <= 4'd0;
            bases_q     <= 2'(BASES);
            quota_q     <= 4'd0;
            res_q       <= 3'b000;
            rr_q        <= 2'd2;
            lfsr_q      <= LFSR_SEED;
            spawn_req_q <= 3'b000;
            target_q    <= 2'd0;
            playing_q   <= 1'b0;
            over_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wave_q      <= wave_d;
            bases_q     <= bases_d;
            quota_q     <= quota_d;
            res_q       <= res_d;
            rr_q        <= rr_d;
            lfsr_q      <= lfsr_d;
            spawn_req_q <= spawn_req_d;
            target_q    <= target_d;
            playing_q   <= playing_d;
            over_q      <= over_d;
            won_q       <= won_d;
        end
    end

    assign spawn_req  = spawn_req_q;
    assign target_sel = target_q;
    assign wave       = wave_q;
    assign bases_left = bases_q;
    assign playing    = playing_q;
    assign game_over  = over_q;
    assign game_won   = won_q;

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(spawn_req_q));
    a_not_active: assert property (@(posedge clk) disable iff (rst)
        (spawn_req_q & slot_active) == 3'b000);

endmodule
